// File: rtl/serial_slice_adder_ctrl_pkg.sv
// serial_slice_adder_ctrl_pkg: FSM encoding, default sizes and index-width helper
package serial_slice_adder_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int SLICE_W_DEF = 3;
  localparam int NUM_SLICES_DEF = 4;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_slice_adder_ctrl_add_slice.sv
// add_slice: combinational SLICE_W-bit ripple adder built from full-adder cells
module add_slice #(
  parameter int SLICE_W = 3
) (
  input  logic               cin,
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);
  logic [SLICE_W:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end
  assign cout = w_c[SLICE_W];
endmodule

// File: rtl/serial_slice_adder_ctrl.sv
// serial_slice_adder_ctrl: wide add via one shared slice, LS slice first, one per clock
// Optional subtract mode enabled by SERIAL_ADD_SUBTRACT_EN.
module serial_slice_adder_ctrl
  import serial_slice_adder_ctrl_pkg::*;
#(
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF,
  localparam int TOT_W     = SLICE_W * NUM_SLICES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c_in,
  input  logic [TOT_W-1:0] a,
  input  logic [TOT_W-1:0] b,
  input  logic             op_sub,
  output logic             busy,
  output logic             done,
  output logic [TOT_W-1:0] sum,
  output logic             c_out
);
  localparam int IW = idx_w(NUM_SLICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);
  state_t            r_state, w_state_nxt;
  logic [TOT_W-1:0]  r_a, r_b, r_sum;
  logic [IW-1:0]     r_idx;
  logic              r_carry, r_cout;
  logic [TOT_W-1:0]  w_b_in;
  logic              w_c_in, w_last, w_co;
  logic [SLICE_W-1:0] w_x, w_y, w_s;
`ifdef SERIAL_ADD_SUBTRACT_EN
  assign w_b_in = op_sub ? ~b : b;
  assign w_c_in = op_sub | c_in;
`else
  logic w_unused;
  assign w_unused = op_sub;
  assign w_b_in   = b;
  assign w_c_in   = c_in;
`endif
  assign w_last = r_idx == LAST;
  assign w_x    = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_y    = r_b[r_idx*SLICE_W +: SLICE_W];
  add_slice #(.SLICE_W(SLICE_W)) u_slice (.cin(r_carry), .x(w_x), .y(w_y), .s(w_s), .cout(w_co));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? (start ? RUN : IDLE) :
                  (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    busy = r_state != IDLE;
    done = r_state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_c_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*SLICE_W +: SLICE_W] <= w_s;
      r_carry <= w_co;
      if (w_last) r_cout <= w_co;
      r_idx   <= w_last ? r_idx : r_idx + 1'b1;
    end
  end
  assign sum   = r_sum;
  assign c_out = r_cout;
endmodule

// File: tb/tb_serial_slice_adder_ctrl.sv
// tb_serial_slice_adder_ctrl: directed vector table plus reset/busy/throughput sequences
module tb_serial_slice_adder_ctrl;
  localparam int TW = 12;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, c_in = 1'b0, op_sub = 1'b0;
  logic [TW-1:0] a = '0, b = '0;
  logic busy, done, c_out;
  logic [TW-1:0] sum;
  int n_run = 0, n_fail = 0;
  typedef struct {
    logic [TW-1:0] a, b;
    logic cin, sub;
    logic [TW-1:0] es;
    logic ec;
  } vec_t;
  vec_t v[9];
  serial_slice_adder_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in), .a(a), .b(b),
    .op_sub(op_sub), .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic run_op(input int id, input vec_t t);
    int lat, bc;
    @(negedge clk);
    a = t.a; b = t.b; c_in = t.cin; op_sub = t.sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~t.a; b = ~t.b; c_in = ~t.cin; op_sub = ~t.sub;
    lat = 0; bc = 0;
    while (!done && lat < 20) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
    bc += int'(busy);
    chk($sformatf("v%0d latency", id), lat, 4);
    chk($sformatf("v%0d busy_cycles", id), bc, 5);
    chk($sformatf("v%0d sum", id), sum, t.es);
    chk($sformatf("v%0d c_out", id), c_out, t.ec);
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", id), done, 0);
    chk($sformatf("v%0d busy_idle", id), busy, 0);
    chk($sformatf("v%0d sum_held", id), sum, t.es);
    chk($sformatf("v%0d c_out_held", id), c_out, t.ec);
  endtask
  initial begin
    int pulses, first, second;
    logic [TW-1:0] cap;
    v[0] = '{12'd7,    12'd1,    1'b0, 1'b0, 12'd8,    1'b0};
    v[1] = '{12'hFFF,  12'h000,  1'b1, 1'b0, 12'h000,  1'b1};
    v[2] = '{12'd2048, 12'd2048, 1'b0, 1'b0, 12'd0,    1'b1};
    v[3] = '{12'd1234, 12'd2345, 1'b0, 1'b0, 12'd3579, 1'b0};
    v[4] = '{12'd0,    12'd0,    1'b1, 1'b0, 12'd1,    1'b0};
    v[5] = '{12'hFFF,  12'hFFF,  1'b1, 1'b0, 12'hFFF,  1'b1};
    v[6] = '{12'h555,  12'hAAA,  1'b0, 1'b0, 12'hFFF,  1'b0};
`ifdef SERIAL_ADD_SUBTRACT_EN
    v[7] = '{12'd10,   12'd3,    1'b0, 1'b1, 12'd7,    1'b1};
    v[8] = '{12'd3,    12'd10,   1'b0, 1'b1, 12'hFF9,  1'b0};
`else
    v[7] = '{12'd10,   12'd3,    1'b0, 1'b1, 12'd13,   1'b0};
    v[8] = '{12'd3,    12'd10,   1'b0, 1'b1, 12'd13,   1'b0};
`endif
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset c_out", c_out, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run_op(i, v[i]);
    // abort mid-RUN with an asynchronous reset
    @(negedge clk);
    a = 12'd100; b = 12'd200; c_in = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-reset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", busy, 0);
    chk("async done", done, 0);
    chk("async sum", sum, 0);
    chk("async c_out", c_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      pulses += int'(done);
    end
    chk("no done after abort", pulses, 0);
    chk("idle after abort", busy, 0);
    // start while busy is ignored
    @(negedge clk);
    a = 12'd5; b = 12'd5; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 12'd1; b = 12'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; cap = '0;
    repeat (10) begin
      if (done) begin
        pulses++;
        cap = sum;
      end
      @(negedge clk);
    end
    chk("busy-start done count", pulses, 1);
    chk("busy-start sum", cap, 12'd10);
    run_op(9, '{12'd1, 12'd1, 1'b0, 1'b0, 12'd2, 1'b0});
    // held start gives one operation every NUM_SLICES+2 cycles
    @(negedge clk);
    a = 12'd1; b = 12'd2; c_in = 1'b0; start = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    start = 1'b0;
    chk("throughput period", second - first, 6);
    repeat (10) @(negedge clk);
    chk("throughput sum", sum, 12'd3);
    chk("throughput idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
